fft_stream_ctrl: RTL and testbench

Parametrised AXI-stream controller that sits between the audio sample source and the FFT core. It sends the transform configuration and buffers incoming real samples into frames of 2^NFFT_LOG2 points. It streams each frame to the core with correct tlast, and selects forward or inverse mode between frames. On the output side it accepts the core's result stream and emits the first-half-spectrum bins as a bin index plus |re|+|im| magnitude.

---
 rtl/fft_stream_pkg.sv | 23 ++
 rtl/fft_stream_ctrl_sync_fifo.sv | 81 ++++++++
 rtl/fft_stream_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fft_stream_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT stream controller.
//   fsm_state_e      : input-side controller states
//   CFG_*_DEFAULT    : default config words for forward / inverse transforms
//   abs_val()        : magnitude of a 32-bit two's-complement value, 33 bits wide so that
//                      the most negative input maps to a positive result without wrapping
package fft_stream_pkg;

    typedef enum logic [1:0] {
        StCfg,
        StFill,
        StStream
    } fsm_state_e;

    localparam logic [7:0] CFG_FWD_DEFAULT = 8'h01;
    localparam logic [7:0] CFG_INV_DEFAULT = 8'h00;

    function automatic logic [32:0] abs_val(input logic [31:0] v);
        logic [32:0] ext;
        ext = {v[31], v};
        return v[31] ? (~ext + 33'd1) : ext;
    endfunction

endpackage

// File: rtl/fft_stream_ctrl_sync_fifo.sv
// Synchronous FIFO with a registered head word.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data; a push into a full FIFO without a pop is dropped
//   pop        : read strobe; ignored when empty
//   head       : oldest stored word, registered, stable until the next pop
//   count      : number of stored words (0..2^FIFO_LOG2)
//   full/empty : occupancy flags
//   dropped    : a push was refused this cycle
module sync_fifo #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_W-1:0]    din,
    input  logic                 pop,
    output logic [DATA_W-1:0]    head,
    output logic [FIFO_LOG2:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 dropped
);

    localparam int unsigned DEPTH = 2 ** FIFO_LOG2;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [FIFO_LOG2:0]   count_q;
    logic [DATA_W-1:0]    head_q;
    logic                 do_push, do_pop;

    assign full       = (count_q == (FIFO_LOG2 + 1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign do_pop     = pop & ~empty;
    // A full FIFO still accepts a push in the same cycle as a pop.
    assign do_push    = push & (~full | do_pop);
    assign dropped    = push & full & ~do_pop;
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;
    assign head       = head_q;
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Head tracks mem[rd_ptr]; when the next word is only arriving this cycle
            // it is taken straight from din.
            if (do_pop) begin
                if (count_q > (FIFO_LOG2 + 1)'(1)) begin
                    head_q <= mem[rd_ptr_nxt];
                end else if (do_push) begin
                    head_q <= din;
                end
            end else if (empty && do_push) begin
                head_q <= din;
            end
        end
    end

endmodule

// File: rtl/fft_stream_ctrl.sv
// AXI-stream controller between an audio sample source and an FFT core.
//   aclk, aresetn            : clock, asynchronous active-low reset (deassertion synchronised)
//   sample_in, sample_valid  : real input samples, buffered into frames of N = 2^NFFT_LOG2
//   inverse                  : transform direction request, taken only at frame boundaries
//   s_axis_config_*          : config word to the core (CFG_FWD / CFG_INV)
//   s_axis_data_*            : frame stream to the core, {real, imag=0}, tlast on point N-1
//   m_axis_data_*            : result stream from the core, bin index in tuser
//   bin_index/bin_mag/bin_valid : first-half-spectrum bins with |re|+|im|, one cycle latency
//   frame_done               : pulse one cycle after the result beat carrying tlast
//   overflow                 : sticky, a sample was dropped because the FIFO was full
module fft_stream_ctrl
    import fft_stream_pkg::*;
#(
    parameter int unsigned      DATA_W    = 16,
    parameter int unsigned      NFFT_LOG2 = 3,
    parameter int unsigned      FIFO_LOG2 = NFFT_LOG2 + 1,
    parameter int unsigned      CFG_W     = 8,
    parameter logic [CFG_W-1:0] CFG_FWD   = CFG_FWD_DEFAULT,
    parameter logic [CFG_W-1:0] CFG_INV   = CFG_INV_DEFAULT
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DATA_W-1:0]      sample_in,
    input  logic                   sample_valid,
    input  logic                   inverse,
    output logic [CFG_W-1:0]       s_axis_config_tdata,
    output logic                   s_axis_config_tvalid,
    input  logic                   s_axis_config_tready,
    output logic [2*DATA_W-1:0]    s_axis_data_tdata,
    output logic                   s_axis_data_tvalid,
    input  logic                   s_axis_data_tready,
    output logic                   s_axis_data_tlast,
    input  logic [2*DATA_W-1:0]    m_axis_data_tdata,
    input  logic [15:0]            m_axis_data_tuser,
    input  logic                   m_axis_data_tvalid,
    output logic                   m_axis_data_tready,
    input  logic                   m_axis_data_tlast,
    output logic [NFFT_LOG2-2:0]   bin_index,
    output logic [DATA_W:0]        bin_mag,
    output logic                   bin_valid,
    output logic                   frame_done,
    output logic                   overflow
);

    localparam int unsigned N     = 2 ** NFFT_LOG2;
    localparam int unsigned MAG_W = DATA_W + 1;
    localparam logic [NFFT_LOG2-1:0] LastBeat = NFFT_LOG2'(N - 1);
    localparam logic [NFFT_LOG2-1:0] PreLast  = NFFT_LOG2'(N - 2);

    // Reset synchroniser: assert immediately, release two clocks later.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Input FIFO
    logic [DATA_W-1:0]  fifo_head;
    logic [FIFO_LOG2:0] fifo_count;
    logic               fifo_full, fifo_empty, fifo_dropped;
    logic               data_hs;

    sync_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (rst_sync_q),
        .push    (sample_valid),
        .din     (sample_in),
        .pop     (data_hs),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    // Input-side FSM
    fsm_state_e           state_q;
    logic                 mode_q;
    logic [CFG_W-1:0]     cfg_tdata_q;
    logic                 cfg_tvalid_q;
    logic                 data_tvalid_q;
    logic                 data_tlast_q;
    logic [NFFT_LOG2-1:0] beat_q;
    logic                 overflow_q;
    logic                 frame_ready, next_frame_ready;

    assign data_hs          = data_tvalid_q & s_axis_data_tready;
    assign frame_ready      = (fifo_count >= (FIFO_LOG2 + 1)'(N));
    // Evaluated on the final pop: at least N words must remain afterwards.
    assign next_frame_ready = (fifo_count > (FIFO_LOG2 + 1)'(N));

    always_ff @(posedge aclk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q       <= StCfg;
            mode_q        <= 1'b0;
            cfg_tdata_q   <= '0;
            cfg_tvalid_q  <= 1'b0;
            data_tvalid_q <= 1'b0;
            data_tlast_q  <= 1'b0;
            beat_q        <= '0;
        end else begin
            case (state_q)
                StCfg: begin
                    if (!cfg_tvalid_q) begin
                        // Only reached straight after reset: take the mode now.
                        mode_q       <= inverse;
                        cfg_tdata_q  <= inverse ? CFG_INV : CFG_FWD;
                        cfg_tvalid_q <= 1'b1;
                    end else if (s_axis_config_tready) begin
                        cfg_tvalid_q <= 1'b0;
                        state_q      <= StFill;
                    end
                end
                StFill: begin
                    if (frame_ready) begin
                        state_q       <= StStream;
                        data_tvalid_q <= 1'b1;
                        data_tlast_q  <= 1'b0;
                        beat_q        <= '0;
                    end
                end
                StStream: begin
                    if (data_hs) begin
                        if (beat_q == LastBeat) begin
                            beat_q       <= '0;
                            data_tlast_q <= 1'b0;
                            if (inverse != mode_q) begin
                                mode_q        <= inverse;
                                cfg_tdata_q   <= inverse ? CFG_INV : CFG_FWD;
                                cfg_tvalid_q  <= 1'b1;
                                data_tvalid_q <= 1'b0;
                                state_q       <= StCfg;
                            end else if (!next_frame_ready) begin
                                data_tvalid_q <= 1'b0;
                                state_q       <= StFill;
                            end
                        end else begin
                            beat_q       <= beat_q + 1'b1;
                            data_tlast_q <= (beat_q == PreLast);
                        end
                    end
                end
                default: state_q <= StCfg;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            overflow_q <= 1'b0;
        end else if (fifo_dropped) begin
            overflow_q <= 1'b1;
        end
    end

    assign s_axis_config_tdata  = cfg_tdata_q;
    assign s_axis_config_tvalid = cfg_tvalid_q;
    assign s_axis_data_tdata    = {fifo_head, {DATA_W{1'b0}}};
    assign s_axis_data_tvalid   = data_tvalid_q;
    assign s_axis_data_tlast    = data_tlast_q;
    assign overflow             = overflow_q;

    // Output path
    logic                   m_tready_q;
    logic                   m_hs;
    logic [NFFT_LOG2-1:0]   m_bin;
    logic                   in_half;
    logic [DATA_W-1:0]      res_re, res_im;
    logic [MAG_W-1:0]       mag_d;
    logic                   bin_valid_q, frame_done_q;
    logic [NFFT_LOG2-2:0]   bin_index_q;
    logic [MAG_W-1:0]       bin_mag_q;

    assign m_hs    = m_axis_data_tvalid & m_tready_q;
    assign m_bin   = m_axis_data_tuser[NFFT_LOG2-1:0];
    assign in_half = ~m_bin[NFFT_LOG2-1];
    assign res_re  = m_axis_data_tdata[2*DATA_W-1:DATA_W];
    assign res_im  = m_axis_data_tdata[DATA_W-1:0];
    // Each |x| fits in DATA_W bits, so the sum always fits in DATA_W+1.
    assign mag_d   = MAG_W'(abs_val(32'($signed(res_re))) + abs_val(32'($signed(res_im))));

    always_ff @(posedge aclk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            m_tready_q   <= 1'b0;
            bin_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bin_index_q  <= '0;
            bin_mag_q    <= '0;
        end else begin
            m_tready_q   <= 1'b1;
            bin_valid_q  <= m_hs & in_half;
            frame_done_q <= m_hs & m_axis_data_tlast;
            if (m_hs && in_half) begin
                bin_index_q <= m_bin[NFFT_LOG2-2:0];
                bin_mag_q   <= mag_d;
            end
        end
    end

    assign m_axis_data_tready = m_tready_q;
    assign bin_valid          = bin_valid_q;
    assign frame_done         = frame_done_q;
    assign bin_index          = bin_index_q;
    assign bin_mag            = bin_mag_q;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed self-checking bench for fft_stream_ctrl (DATA_W=16, N=8, FIFO depth 16).
module tb_fft_stream_ctrl;

    localparam int DW = 16;
    localparam int L  = 3;
    localparam int N  = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          inverse = 1'b0;
    logic [7:0]    cfg_tdata;
    logic          cfg_tvalid;
    logic          cfg_tready = 1'b0;
    logic [2*DW-1:0] data_tdata;
    logic          data_tvalid;
    logic          data_tready = 1'b0;
    logic          data_tlast;
    logic [2*DW-1:0] m_tdata = '0;
    logic [15:0]   m_tuser = '0;
    logic          m_tvalid = 1'b0;
    logic          m_tready;
    logic          m_tlast = 1'b0;
    logic [L-2:0]  bin_index;
    logic [DW:0]   bin_mag;
    logic          bin_valid;
    logic          frame_done;
    logic          overflow;

    always #5 aclk = ~aclk;

    fft_stream_ctrl dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .sample_in            (sample_in),
        .sample_valid         (sample_valid),
        .inverse              (inverse),
        .s_axis_config_tdata  (cfg_tdata),
        .s_axis_config_tvalid (cfg_tvalid),
        .s_axis_config_tready (cfg_tready),
        .s_axis_data_tdata    (data_tdata),
        .s_axis_data_tvalid   (data_tvalid),
        .s_axis_data_tready   (data_tready),
        .s_axis_data_tlast    (data_tlast),
        .m_axis_data_tdata    (m_tdata),
        .m_axis_data_tuser    (m_tuser),
        .m_axis_data_tvalid   (m_tvalid),
        .m_axis_data_tready   (m_tready),
        .m_axis_data_tlast    (m_tlast),
        .bin_index            (bin_index),
        .bin_mag              (bin_mag),
        .bin_valid            (bin_valid),
        .frame_done           (frame_done),
        .overflow             (overflow)
    );

    int checks = 0;
    int failures = 0;
    int next_sample = 1;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // data tready driver: 0 = low, 1 = high, 2 = toggle every cycle
    int tready_mode = 0;
    always @(posedge aclk) begin
        #1;
        case (tready_mode)
            0:       data_tready = 1'b0;
            1:       data_tready = 1'b1;
            default: data_tready = ~data_tready;
        endcase
    end

    // Beat monitor: records beats that will be accepted at the next edge and checks that a
    // stalled beat is held unchanged.
    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
        int            cyc;
    } beat_t;
    beat_t beats[$];
    logic            prev_stall = 1'b0;
    logic [2*DW-1:0] prev_data;
    logic            prev_last;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall) begin
                checks++;
                if (!(data_tvalid && data_tdata == prev_data && data_tlast == prev_last)) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                             data_tvalid, data_tdata, data_tlast, prev_data, prev_last);
                end
            end
            if (data_tvalid && data_tready) begin
                beats.push_back('{data_tdata[2*DW-1:DW], data_tdata[DW-1:0], data_tlast, cyc});
            end
            prev_stall = data_tvalid && !data_tready;
            prev_data  = data_tdata;
            prev_last  = data_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_samples(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
            sample_in    = DW'(next_sample);
            sample_valid = 1'b1;
            next_sample++;
        end
        @(posedge aclk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_cfg_valid(input string name);
        int n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!cfg_tvalid && n < 30);
        check(name, cfg_tvalid, 1'b1);
    endtask

    task automatic expect_frame(input int first, output int c0, output int c1);
        int n = 0;
        c0 = 0;
        c1 = 0;
        while (beats.size() < N && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (beats.size() < N) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got %0d beats expected %0d", beats.size(), N);
            beats.delete();
            return;
        end
        for (int k = 0; k < N; k++) begin
            beat_t b;
            b = beats.pop_front();
            check("beat_real", b.re, DW'(first + k));
            check("beat_imag", b.im, 0);
            check("beat_tlast", b.last, (k == N - 1));
            if (k == 0) c0 = b.cyc;
            if (k == N - 1) c1 = b.cyc;
        end
    endtask

    typedef struct {
        logic [15:0] tuser;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
        logic        exp_valid;
        logic [1:0]  exp_idx;
        logic [16:0] exp_mag;
    } res_vec_t;
    res_vec_t tbl[8];

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int f0, f1, g0, g1;

        tbl[0] = '{16'd0,     16'd100,   16'hFFCE, 1'b0, 1'b1, 2'd0, 17'd150};
        tbl[1] = '{16'h0101,  16'hFFFF,  16'hFFFF, 1'b0, 1'b1, 2'd1, 17'd2};
        tbl[2] = '{16'd2,     16'h8000,  16'd5,    1'b0, 1'b1, 2'd2, 17'd32773};
        tbl[3] = '{16'd3,     16'h8000,  16'h8000, 1'b0, 1'b1, 2'd3, 17'd65536};
        tbl[4] = '{16'd4,     16'd7,     16'd7,    1'b0, 1'b0, 2'd0, 17'd0};
        tbl[5] = '{16'd5,     16'h8000,  16'h8000, 1'b0, 1'b0, 2'd0, 17'd0};
        tbl[6] = '{16'd6,     16'd1,     16'd2,    1'b0, 1'b0, 2'd0, 17'd0};
        tbl[7] = '{16'd7,     16'd3,     16'd4,    1'b1, 1'b0, 2'd0, 17'd0};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_cfg_tvalid", cfg_tvalid, 0);
        check("rst_cfg_tdata", cfg_tdata, 0);
        check("rst_data_tvalid", data_tvalid, 0);
        check("rst_data_tlast", data_tlast, 0);
        check("rst_m_tready", m_tready, 0);
        check("rst_bin_valid", bin_valid, 0);
        check("rst_bin_mag", bin_mag, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        aresetn = 1'b1;

        // Config handshake with tready delayed 3 cycles
        wait_cfg_valid("cfg_initial_valid");
        for (int k = 0; k < 4; k++) begin
            check("cfg_hold_valid", cfg_tvalid, 1);
            check("cfg_hold_fwd", cfg_tdata, 8'h01);
            if (k == 3) cfg_tready = 1'b1;
            @(negedge aclk);
        end
        cfg_tready = 1'b0;
        check("cfg_drop_after_hs", cfg_tvalid, 0);
        check("m_tready_high", m_tready, 1);
        check("fill_no_data", data_tvalid, 0);

        // One frame, tready high
        tready_mode = 1;
        push_samples(N);
        expect_frame(1, f0, f1);
        check("frame1_contiguous", f1 - f0, N - 1);

        // One frame, tready toggling
        tready_mode = 2;
        push_samples(N);
        expect_frame(9, f0, f1);
        repeat (6) @(negedge aclk);
        check("toggle_no_extra", beats.size(), 0);

        // Mode change mid-frame
        tready_mode = 0;
        push_samples(N);
        tready_mode = 1;
        begin
            int n = 0;
            while (beats.size() < 4 && n < 50) begin
                @(negedge aclk);
                n++;
            end
        end
        inverse = 1'b1;
        expect_frame(17, f0, f1);
        wait_cfg_valid("cfg_inv_valid");
        check("cfg_inv_word", cfg_tdata, 8'h00);
        push_samples(N);
        repeat (4) @(negedge aclk);
        check("cfg_blocks_stream", beats.size(), 0);
        check("cfg_blocks_tvalid", data_tvalid, 0);
        check("cfg_inv_still_valid", cfg_tvalid, 1);
        cfg_tready = 1'b1;
        @(negedge aclk);
        cfg_tready = 1'b0;
        check("cfg_inv_done", cfg_tvalid, 0);
        expect_frame(25, f0, f1);

        // Overflow: 24 samples while the core stalls
        tready_mode = 0;
        repeat (2) @(posedge aclk);
        for (int i = 0; i < 24; i++) begin
            @(posedge aclk); #1;
            sample_in    = DW'(next_sample);
            sample_valid = 1'b1;
            next_sample++;
            @(negedge aclk);
            check("overflow_progress", overflow, (i >= 17));
        end
        @(posedge aclk); #1;
        sample_valid = 1'b0;
        @(negedge aclk);
        check("overflow_sticky", overflow, 1);
        tready_mode = 1;
        expect_frame(33, f0, f1);
        expect_frame(41, g0, g1);
        check("back_to_back", g0 - f1, 1);
        repeat (10) @(negedge aclk);
        check("dropped_not_sent", beats.size(), 0);
        check("overflow_still_set", overflow, 1);

        // Result path, pipelined one beat per clock
        for (int i = 0; i <= 8; i++) begin
            @(posedge aclk); #1;
            if (i < 8) begin
                m_tdata  = {tbl[i].re, tbl[i].im};
                m_tuser  = tbl[i].tuser;
                m_tlast  = tbl[i].last;
                m_tvalid = 1'b1;
            end else begin
                m_tvalid = 1'b0;
                m_tlast  = 1'b0;
            end
            @(negedge aclk);
            if (i > 0) begin
                check("bin_valid", bin_valid, tbl[i-1].exp_valid);
                check("frame_done", frame_done, tbl[i-1].last);
                if (tbl[i-1].exp_valid) begin
                    check("bin_index", bin_index, tbl[i-1].exp_idx);
                    check("bin_mag", bin_mag, tbl[i-1].exp_mag);
                end
            end
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        check("idle_bin_valid", bin_valid, 0);
        check("idle_frame_done", frame_done, 0);

        // Reset with a partial frame buffered
        push_samples(5);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #2;
        check("midrst_cfg_tvalid", cfg_tvalid, 0);
        check("midrst_data_tvalid", data_tvalid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_m_tready", m_tready, 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        beats.delete();
        wait_cfg_valid("cfg_resent_valid");
        check("cfg_resent_word", cfg_tdata, 8'h00);
        cfg_tready = 1'b1;
        @(negedge aclk);
        cfg_tready = 1'b0;
        check("cfg_resent_done", cfg_tvalid, 0);
        push_samples(N);
        expect_frame(62, f0, f1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
